// File: rtl/req_grant_seq_pkg.sv
// ============================================================================
// Module : req_grant_seq_pkg
// Desc   : Shared types and width helpers for the request/grant sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package req_grant_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BACKOFF = 2'd2
    } state_e;

    function automatic int id_w(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

    // One counter serves both hold time and backoff, so it must fit the larger.
    function automatic int cnt_w(input int hold_max, input int backoff_cyc);
        int a;
        int b;
        a = $clog2(hold_max + 1);
        b = $clog2(backoff_cyc + 1);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/req_seq_rr_pick.sv
// ============================================================================
// Module : req_seq_rr_pick
// Desc   : Combinational round-robin picker; first set request from ptr_i up.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module req_seq_rr_pick
    import req_grant_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             any_o,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o
);

    always_comb begin
        any_o = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (int'(ptr_i) + i) % N_REQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/req_grant_sequencer.sv
// ============================================================================
// Module : req_grant_sequencer
// Desc   : Round-robin grant controller with hold timeout and recovery backoff.
//          Define REQ_GRANT_SEQ_SVA_EN to embed protocol assertions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module req_grant_sequencer
    import req_grant_seq_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_MAX    = 16,
    parameter int BACKOFF_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     done_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [id_w(N_REQ)-1:0]   gnt_id_o,
    output logic                     busy_o,
    output logic                     idle_o,
    output logic                     timeout_o
);

    localparam int ID_W  = id_w(N_REQ);
    localparam int CNT_W = cnt_w(HOLD_MAX, BACKOFF_CYC);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               busy_q, busy_d;
    logic               idle_q, idle_d;
    logic               timeout_q, timeout_d;

    logic               pick_any;
    logic [N_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W-1:0]    next_ptr;

    req_seq_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign next_ptr = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        idle_d    = idle_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = GRANT;
                    gnt_d    = pick_gnt;
                    gnt_id_d = pick_idx;
                    busy_d   = 1'b1;
                    idle_d   = 1'b0;
                    cnt_d    = CNT_W'(1);
                    ptr_d    = next_ptr;
                end
            end
            GRANT: begin
                // done_i takes priority over a coincident hold expiry.
                if (done_i) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                    idle_d   = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(HOLD_MAX)) begin
                    state_d   = BACKOFF;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    timeout_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BACKOFF: begin
                if (cnt_q == CNT_W'(BACKOFF_CYC)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    idle_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                idle_d   = 1'b1;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            idle_q    <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign busy_o    = busy_q;
    assign idle_o    = idle_q;
    assign timeout_o = timeout_q;

`ifdef REQ_GRANT_SEQ_SVA_EN
    a_arb_latency: assert property (@(posedge clk) disable iff (!rst_n)
        (|req_i && !busy_o) |=> (busy_o && !idle_o && $onehot(gnt_o)))
        $info("a_arb_latency pass at %0t", $time);
        else $error("a_arb_latency fail at %0t", $time);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_o))
        $info("a_gnt_onehot0 pass at %0t", $time);
        else $error("a_gnt_onehot0 fail at %0t", $time);

    a_idle_busy: assert property (@(posedge clk) disable iff (!rst_n)
        idle_o == !busy_o)
        $info("a_idle_busy pass at %0t", $time);
        else $error("a_idle_busy fail at %0t", $time);

    a_timeout_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        timeout_o |=> !timeout_o)
        $info("a_timeout_pulse pass at %0t", $time);
        else $error("a_timeout_pulse fail at %0t", $time);

    a_gnt_id: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_o != '0) |-> (gnt_o == (N_REQ'(1) << gnt_id_o)))
        $info("a_gnt_id pass at %0t", $time);
        else $error("a_gnt_id fail at %0t", $time);
`endif

endmodule

`default_nettype wire

// File: tb/tb_req_grant_sequencer.sv
// ============================================================================
// Module : tb_req_grant_sequencer
// Desc   : Directed self-checking bench, N_REQ=4 HOLD_MAX=4 BACKOFF_CYC=2.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_req_grant_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_i;
    logic       done_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_id_o;
    logic       busy_o;
    logic       idle_o;
    logic       timeout_o;

    int n_cmp;
    int n_err;

    req_grant_sequencer #(
        .N_REQ       (4),
        .HOLD_MAX    (4),
        .BACKOFF_CYC (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_id_o  (gnt_id_o),
        .busy_o    (busy_o),
        .idle_o    (idle_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gnt_id_o is only compared when a grant is expected, or when use_id forces it.
    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic ei, input logic et, input logic use_id);
        logic [8:0] obs;
        logic [8:0] exp;
        logic       cmp_id;
        cmp_id = use_id || (eg != 4'b0000);
        obs = {gnt_o, cmp_id ? gnt_id_o : 2'b00, busy_o, idle_o, timeout_o};
        exp = {eg,    cmp_id ? eid      : 2'b00, eb,     ei,     et};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed gnt/id/busy/idle/to=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check(tag, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic chk_idle(input string tag);
        check(tag, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_gnt(input string tag, input int g);
        check(tag, 4'b0001 << g, 2'(g), 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_reset("reset_async");
        tick();
        tick();
        chk_reset("reset_held");
        rst_n = 1'b1;
    endtask

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};
        n_cmp  = 0;
        n_err  = 0;
        req_i  = 4'b0000;
        done_i = 1'b0;
        rst_n  = 1'b1;
        #2;
        do_reset();

        // 1: single request granted one edge later
        req_i = 4'b0100;
        tick();
        chk_gnt("t1_grant2", 2);
        req_i  = 4'b0000;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk_idle("t1_release");

        // 2: fair rotation from ptr=0, one IDLE cycle between grants
        do_reset();
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_gnt($sformatf("t2_g%0d_c1", k), order[k]);
            tick();
            chk_gnt($sformatf("t2_g%0d_c2", k), order[k]);
            done_i = 1'b1;
            tick();
            done_i = 1'b0;
            chk_idle($sformatf("t2_g%0d_idle", k));
        end

        // 3: timeout on requester 1 (ptr=1), backoff ignores requests
        req_i = 4'b0010;
        tick();
        chk_gnt("t3_grant1", 1);
        req_i = 4'b0000;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk_gnt($sformatf("t3_hold%0d", c), 1);
        end
        tick();
        check("t3_backoff1", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        req_i = 4'b1111;
        tick();
        check("t3_backoff2", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_idle("t3_idle_after_backoff");
        tick();
        chk_gnt("t6_first_idle_grant2", 2);
        req_i = 4'b0000;

        // 4: done in the final hold cycle beats expiry
        tick();
        chk_gnt("t4_hold2", 2);
        tick();
        chk_gnt("t4_hold3", 2);
        tick();
        chk_gnt("t4_hold4", 2);
        done_i = 1'b1;
        tick();
        chk_idle("t4_done_wins");
        tick();
        chk_idle("t4_done_ignored_idle");
        done_i = 1'b0;

        // 6: grant holds after request drops (ptr=3, scan wraps to 0)
        req_i = 4'b0001;
        tick();
        chk_gnt("t6_grant0", 0);
        req_i = 4'b0000;
        tick();
        chk_gnt("t6_hold_after_drop2", 0);
        tick();
        chk_gnt("t6_hold_after_drop3", 0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk_idle("t6_release");

        // 5: reset mid-grant; pointer returns to 0
        req_i = 4'b0100;
        tick();
        chk_gnt("t5_grant2", 2);
        req_i = 4'b1010;
        do_reset();
        tick();
        chk_gnt("t5_ptr0_grant1", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
